// File: rtl/beam_index_reader.sv
// Per-RBG beam index latch and COL:SEL column selector producing the reduced-dimension PUSCH stream.
// Build option: define BEAM_SEL_OREG_EN to add an output register stage after the selection mux.
module beam_index_reader #(
  parameter int unsigned IW      = 32,
  parameter int unsigned COL     = 64,
  parameter int unsigned SEL     = 16,
  parameter int unsigned RBG_LEN = 12,
  parameter int unsigned RD_LAT  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_idx_sop,
  input  logic [SEL-1:0][7:0]      i_beam_index,
  input  logic [7:0]               i_rbg_max,
  input  logic [COL-1:0][IW-1:0]   i_data,
  input  logic                     i_dvalid,
  input  logic                     i_dsop,
  output logic                     o_bid_rden,
  output logic [7:0]               o_rbg_max,
  output logic [SEL-1:0][IW-1:0]   o_data,
  output logic [SEL-1:0][7:0]      o_beam_index,
  output logic                     o_tvalid,
  output logic                     o_sop,
  output logic                     o_eop,
  output logic [7:0]               o_rbg_num,
  output logic                     o_err
);

  localparam int unsigned RW = (RBG_LEN > 1) ? $clog2(RBG_LEN) : 1;
  localparam int unsigned CW = (COL > 1) ? $clog2(COL) : 1;

  // The next index vector must settle before the following RBG's first beat.
  if (RBG_LEN <= RD_LAT) begin : g_bad_cfg
    $error("beam_index_reader: RBG_LEN must be greater than RD_LAT");
  end

  typedef enum logic [1:0] {IDLE, WAIT_SOP, RUN} state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   re_cnt_q, re_cnt_d;
  logic [7:0]      rbg_cnt_q, rbg_cnt_d;
  logic            accept, misalign, latch, first_beat, last_beat;
  logic [RW-1:0]   eff_re;
  logic [7:0]      eff_rbg;

  logic                   s1_vld_q, s1_sop_q, s1_eop_q, s1_mis_q;
  logic [7:0]             s1_rbg_q;
  logic [COL-1:0][IW-1:0] s1_data_q;
  logic [SEL-1:0][7:0]    cur_idx_q;
  logic                   rden_q;
  logic [7:0]             rbg_max_q;

  logic [SEL-1:0][IW-1:0] mux_data;
  logic                   bad_idx;

  logic                   s2_vld_q, s2_sop_q, s2_eop_q, s2_err_q;
  logic [7:0]             s2_rbg_q;
  logic [SEL-1:0][IW-1:0] s2_data_q;
  logic [SEL-1:0][7:0]    s2_idx_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      re_cnt_q  <= '0;
      rbg_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      re_cnt_q  <= re_cnt_d;
      rbg_cnt_q <= rbg_cnt_d;
    end
  end

  // A symbol start always restarts the counters as RBG 0 beat 0.
  always_comb begin
    state_d    = state_q;
    re_cnt_d   = re_cnt_q;
    rbg_cnt_d  = rbg_cnt_q;
    accept     = 1'b0;
    misalign   = 1'b0;
    eff_re     = re_cnt_q;
    eff_rbg    = rbg_cnt_q;
    case (state_q)
      IDLE: begin
        if (i_idx_sop) state_d = WAIT_SOP;
      end
      WAIT_SOP: begin
        if (i_dvalid && i_dsop) begin
          state_d = RUN;
          accept  = 1'b1;
        end
      end
      RUN: begin
        accept = i_dvalid;
      end
      default: state_d = IDLE;
    endcase
    if (accept && i_dsop) begin
      misalign = (state_q == RUN) && ((re_cnt_q != '0) || (rbg_cnt_q != '0));
      eff_re   = '0;
      eff_rbg  = '0;
    end
    if (accept) begin
      if (eff_re == RW'(RBG_LEN - 1)) begin
        re_cnt_d  = '0;
        rbg_cnt_d = (eff_rbg >= i_rbg_max) ? 8'd0 : eff_rbg + 8'd1;
      end else begin
        re_cnt_d  = eff_re + RW'(1);
        rbg_cnt_d = eff_rbg;
      end
    end
    latch      = accept && (eff_re == '0);
    first_beat = (eff_re == '0) && (eff_rbg == '0);
    last_beat  = (eff_re == RW'(RBG_LEN - 1)) && (eff_rbg == i_rbg_max);
  end

  // Stage 1: capture beat, flags and the per-RBG index vector.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_vld_q  <= 1'b0;
      s1_sop_q  <= 1'b0;
      s1_eop_q  <= 1'b0;
      s1_mis_q  <= 1'b0;
      s1_rbg_q  <= '0;
      s1_data_q <= '0;
      cur_idx_q <= '0;
      rden_q    <= 1'b0;
      rbg_max_q <= '0;
    end else begin
      s1_vld_q  <= accept;
      rden_q    <= latch;
      rbg_max_q <= i_rbg_max;
      if (accept) begin
        s1_data_q <= i_data;
        s1_sop_q  <= first_beat;
        s1_eop_q  <= last_beat;
        s1_mis_q  <= misalign;
        s1_rbg_q  <= eff_rbg;
      end
      if (latch) cur_idx_q <= i_beam_index;
    end
  end

  // Out-of-range lanes read as zero and raise the error flag.
  always_comb begin
    mux_data = '0;
    bad_idx  = 1'b0;
    for (int k = 0; k < int'(SEL); k++) begin
      if (32'(cur_idx_q[k]) < 32'(COL)) mux_data[k] = s1_data_q[cur_idx_q[k][CW-1:0]];
      else                              bad_idx     = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s2_vld_q  <= 1'b0;
      s2_sop_q  <= 1'b0;
      s2_eop_q  <= 1'b0;
      s2_err_q  <= 1'b0;
      s2_rbg_q  <= '0;
      s2_data_q <= '0;
      s2_idx_q  <= '0;
    end else begin
      s2_vld_q <= s1_vld_q;
      s2_err_q <= s2_err_q | (s1_vld_q & (s1_mis_q | bad_idx));
      if (s1_vld_q) begin
        s2_sop_q  <= s1_sop_q;
        s2_eop_q  <= s1_eop_q;
        s2_rbg_q  <= s1_rbg_q;
        s2_data_q <= mux_data;
        s2_idx_q  <= cur_idx_q;
      end
    end
  end

`ifdef BEAM_SEL_OREG_EN
  logic                   s3_vld_q, s3_sop_q, s3_eop_q, s3_err_q;
  logic [7:0]             s3_rbg_q;
  logic [SEL-1:0][IW-1:0] s3_data_q;
  logic [SEL-1:0][7:0]    s3_idx_q;

  // Extra retiming stage for the wide selection mux.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s3_vld_q  <= 1'b0;
      s3_sop_q  <= 1'b0;
      s3_eop_q  <= 1'b0;
      s3_err_q  <= 1'b0;
      s3_rbg_q  <= '0;
      s3_data_q <= '0;
      s3_idx_q  <= '0;
    end else begin
      s3_vld_q  <= s2_vld_q;
      s3_sop_q  <= s2_sop_q;
      s3_eop_q  <= s2_eop_q;
      s3_err_q  <= s2_err_q;
      s3_rbg_q  <= s2_rbg_q;
      s3_data_q <= s2_data_q;
      s3_idx_q  <= s2_idx_q;
    end
  end

  assign o_tvalid     = s3_vld_q;
  assign o_sop        = s3_sop_q;
  assign o_eop        = s3_eop_q;
  assign o_err        = s3_err_q;
  assign o_rbg_num    = s3_rbg_q;
  assign o_data       = s3_data_q;
  assign o_beam_index = s3_idx_q;
`else
  assign o_tvalid     = s2_vld_q;
  assign o_sop        = s2_sop_q;
  assign o_eop        = s2_eop_q;
  assign o_err        = s2_err_q;
  assign o_rbg_num    = s2_rbg_q;
  assign o_data       = s2_data_q;
  assign o_beam_index = s2_idx_q;
`endif

  assign o_bid_rden = rden_q;
  assign o_rbg_max  = rbg_max_q;

endmodule

// File: tb/tb_beam_index_reader.sv
// Testbench for beam_index_reader: random beats against a beat-position reference model and a sorter BRAM model.
module tb_beam_index_reader;
  localparam int unsigned IW      = 32;
  localparam int unsigned COL     = 64;
  localparam int unsigned SEL     = 16;
  localparam int unsigned RBG_LEN = 12;
  localparam int unsigned RD_LAT  = 4;
`ifdef BEAM_SEL_OREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int NCYC = 2048;

  typedef logic [SEL-1:0][7:0]    idx_t;
  typedef logic [SEL-1:0][IW-1:0] sel_t;
  typedef struct packed {
    logic       vld;
    logic       sop;
    logic       eop;
    logic [7:0] rbg;
    idx_t       idx;
    sel_t       data;
  } obeat_t;

  logic                   i_clk, i_reset, i_idx_sop, i_dvalid, i_dsop;
  idx_t                   i_beam_index;
  logic [7:0]             i_rbg_max;
  logic [COL-1:0][IW-1:0] i_data;
  logic                   o_bid_rden, o_tvalid, o_sop, o_eop, o_err;
  logic [7:0]             o_rbg_max, o_rbg_num;
  sel_t                   o_data;
  idx_t                   o_beam_index;

  beam_index_reader #(.IW(IW), .COL(COL), .SEL(SEL), .RBG_LEN(RBG_LEN), .RD_LAT(RD_LAT)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_idx_sop(i_idx_sop), .i_beam_index(i_beam_index),
    .i_rbg_max(i_rbg_max), .i_data(i_data), .i_dvalid(i_dvalid), .i_dsop(i_dsop),
    .o_bid_rden(o_bid_rden), .o_rbg_max(o_rbg_max), .o_data(o_data), .o_beam_index(o_beam_index),
    .o_tvalid(o_tvalid), .o_sop(o_sop), .o_eop(o_eop), .o_rbg_num(o_rbg_num), .o_err(o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  obeat_t     exp_o     [NCYC];
  logic       exp_rden  [NCYC];
  logic [7:0] exp_rmax  [NCYC];
  int         addr_hist [NCYC];
  idx_t       tab       [8];

  int   n_cmp, n_bad, cyc, addr, bram_rst, rden_cnt, bpos;
  logic armed, running, m_err, rst_prev, align_chk, basic_chk, rand_data;
  idx_t m_cur;
  sel_t basic_exp;

  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  // Advance one clock, play the sorter BRAM address, and check every output.
  task automatic tick();
    @(posedge i_clk);
    #1;
    cyc++;
    if (o_bid_rden === 1'b1) begin
      rden_cnt++;
      addr = (addr >= int'(i_rbg_max)) ? 0 : addr + 1;
    end
    addr_hist[cyc] = addr;
    chk("tvalid", o_tvalid, exp_o[cyc].vld);
    chk("rden", o_bid_rden, exp_rden[cyc]);
    chk("rbg_max", o_rbg_max, exp_rmax[cyc]);
    if (exp_o[cyc].vld) begin
      chk("data", o_data, exp_o[cyc].data);
      chk("bidx", o_beam_index, exp_o[cyc].idx);
      chk("sop", o_sop, exp_o[cyc].sop);
      chk("eop", o_eop, exp_o[cyc].eop);
      chk("rbg_num", o_rbg_num, exp_o[cyc].rbg);
      if (align_chk) chk("align", o_beam_index, tab[exp_o[cyc].rbg[2:0]]);
      if (basic_chk) chk("basic", o_data, basic_exp);
    end
    if (rst_prev) begin
      chk("rst_ctl", {o_tvalid, o_sop, o_eop, o_err, o_bid_rden, o_rbg_max, o_rbg_num}, '0);
      chk("rst_data", o_data, '0);
      chk("rst_bidx", o_beam_index, '0);
    end
  endtask

  // Reference: beat position within the symbol decides RBG, beat and flags.
  task automatic model();
    logic   acc;
    int     nb, re, rbg;
    obeat_t e;
    exp_rden[cyc+1] = 1'b0;
    exp_rmax[cyc+1] = i_reset ? 8'd0 : i_rbg_max;
    if (i_reset) begin
      for (int d = 1; d <= LAT; d++) exp_o[cyc+d] = '0;
      armed = 0; running = 0; bpos = 0; m_err = 0; addr = 0; bram_rst = cyc + 1;
      return;
    end
    acc = 1'b0;
    if (running) acc = i_dvalid;
    else if (armed) begin
      if (i_dvalid && i_dsop) begin running = 1; acc = 1'b1; end
    end else if (i_idx_sop) armed = 1;
    if (!acc) return;
    nb = (int'(i_rbg_max) + 1) * int'(RBG_LEN);
    if (i_dsop) begin
      if (bpos != 0) m_err = 1;
      bpos = 0;
    end
    re  = bpos % int'(RBG_LEN);
    rbg = bpos / int'(RBG_LEN);
    if (re == 0) begin
      m_cur = i_beam_index;
      exp_rden[cyc+1] = 1'b1;
    end
    e = '0;
    e.vld = 1'b1;
    e.sop = (bpos == 0);
    e.eop = (bpos == nb - 1);
    e.rbg = 8'(rbg);
    e.idx = m_cur;
    for (int k = 0; k < int'(SEL); k++) begin
      if (int'(m_cur[k]) < int'(COL)) e.data[k] = i_data[m_cur[k]];
      else m_err = 1;
    end
    exp_o[cyc+LAT] = e;
    bpos = (bpos + 1) % nb;
  endtask

  task automatic cycle(input logic v, input logic s, input logic isop, input logic rst);
    int a;
    tick();
    rst_prev = rst;
    if (cyc + LAT + 1 >= NCYC) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, NCYC);
      $fatal(1, "cycle budget exhausted");
    end
    a = (cyc - int'(RD_LAT) >= bram_rst) ? addr_hist[cyc - int'(RD_LAT)] : 0;
    i_beam_index = tab[a];
    i_dvalid  = v;
    i_dsop    = s;
    i_idx_sop = isop;
    i_reset   = rst;
    for (int c = 0; c < int'(COL); c++) i_data[c] = rand_data ? $urandom() : 32'(c + 100);
    model();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic rand_tab();
    for (int n = 0; n < 8; n++)
      for (int k = 0; k < int'(SEL); k++) tab[n][k] = 8'($urandom_range(0, COL - 1));
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; addr = 0; bram_rst = 0; rden_cnt = 0; bpos = 0;
    armed = 0; running = 0; m_err = 0; m_cur = '0; align_chk = 0; basic_chk = 0; rand_data = 0;
    for (int i = 0; i < NCYC; i++) begin
      exp_o[i] = '0; exp_rden[i] = 1'b0; exp_rmax[i] = '0; addr_hist[i] = 0;
    end
    for (int k = 0; k < int'(SEL); k++) basic_exp[k] = 32'(148 + k);
    for (int n = 0; n < 8; n++)
      for (int k = 0; k < int'(SEL); k++) tab[n][k] = 8'(48 + k);

    i_reset = 1'b1; i_idx_sop = 1'b0; i_dvalid = 1'b0; i_dsop = 1'b0;
    i_rbg_max = 8'd3; i_beam_index = tab[0]; i_data = '0;
    rst_prev = 1'b1;
    model();
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Basic selection: columns c+100, vector {63..48}; a pre-sop beat is dropped.
    basic_chk = 1;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 48; i++) cycle(1'b1, i == 0, 1'b0, 1'b0);
    idle(LAT + 2);
    basic_chk = 0;
    chk("rden_basic", 32'(rden_cnt), 32'd4);
    chk("err_basic", o_err, 1'b0);

    // RBG stepping over two symbols with a live BRAM model.
    do_reset();
    rand_tab();
    rand_data = 1; align_chk = 1; rden_cnt = 0;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 96; i++) cycle(1'b1, (i % 48) == 0, 1'b0, 1'b0);
    idle(LAT + 2);
    chk("rden_step", 32'(rden_cnt), 32'd8);
    chk("err_step", o_err, m_err);

    // Reset mid-RUN, dropped beats before re-arm, then gappy input.
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    rden_cnt = 0;
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 96; i++) begin
      cycle(1'b1, (i % 48) == 0, 1'b0, 1'b0);
      idle(($urandom_range(0, 3) == 0) ? 2 : 1);
    end
    idle(LAT + 2);
    chk("rden_gap", 32'(rden_cnt), 32'd8);
    chk("err_gap", o_err, 1'b0);

    // Out-of-range index in RBG 1.
    do_reset();
    rand_tab();
    tab[1][3] = 8'd70;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b1, i == 0, 1'b0, 1'b0);
    idle(LAT + 1);
    chk("err_pre", o_err, 1'b0);
    for (int i = 12; i < 48; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(LAT + 2);
    chk("err_idx", o_err, 1'b1);
    chk("err_idx_model", o_err, m_err);

    // Early symbol start at beat 5 of RBG 0.
    do_reset();
    rand_tab();
    align_chk = 0;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, i == 0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("early_rden", o_bid_rden, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(LAT + 2);
    chk("err_early", o_err, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
